// File: rtl/decode_pkg.sv
// decode_pkg: shared constants and types for the DECODE pipeline stage.
//   - opcode constants for the reserved and jump opcodes
//   - bit positions of the instruction word fields
//   - FSM state encoding and the EXECUTE output packet
package decode_pkg;

  localparam logic [3:0] OP_RSVD = 4'hE;
  localparam logic [3:0] OP_JMP  = 4'hF;

  // Instruction word layout: [15:12] op, [11:8] dst, [7:4] src, [3] I.
  // For relative jumps, [11:4] is a signed 8-bit word offset.
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int DST_MSB = 11;
  localparam int DST_LSB = 8;
  localparam int SRC_MSB = 7;
  localparam int SRC_LSB = 4;
  localparam int IMM_BIT = 3;
  localparam int OFS_MSB = 11;
  localparam int OFS_LSB = 4;

  typedef enum logic [0:0] {
    ST_OP  = 1'b0,  // awaiting an opcode word
    ST_IMM = 1'b1   // awaiting the immediate word of a latched opcode
  } state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [3:0]  op;
    logic [3:0]  dst;
    logic [3:0]  src;
    logic        imm_valid;
    logic [15:0] imm;
  } ex_pkt_t;

endpackage

// File: rtl/decode_instr.sv
// decode_instr: purely combinational decode of one instruction word.
//   word_i       : instruction word
//   addr_i       : address of that word
//   op_o/dst_o/src_o : extracted fields
//   is_alu_o     : opcode is an ALU operation (0x0-0xD)
//   is_jmp_o     : opcode is JMP (0xF)
//   needs_imm_o  : a second (immediate/target) word follows; never for reserved
//   rel_target_o : addr_i + 1 + sign-extended [11:4], modulo 2^16
module decode_instr
  import decode_pkg::*;
(
  input  logic [15:0] word_i,
  input  logic [15:0] addr_i,
  output logic [3:0]  op_o,
  output logic [3:0]  dst_o,
  output logic [3:0]  src_o,
  output logic        is_alu_o,
  output logic        is_jmp_o,
  output logic        needs_imm_o,
  output logic [15:0] rel_target_o
);

  logic [7:0] ofs_s;
  logic       is_rsvd_s;
  logic       unused_s;

  assign op_o  = word_i[OP_MSB:OP_LSB];
  assign dst_o = word_i[DST_MSB:DST_LSB];
  assign src_o = word_i[SRC_MSB:SRC_LSB];
  assign ofs_s = word_i[OFS_MSB:OFS_LSB];

  assign is_jmp_o    = (op_o == OP_JMP);
  assign is_rsvd_s   = (op_o == OP_RSVD);
  assign is_alu_o    = !is_jmp_o && !is_rsvd_s;
  // The reserved opcode is always a single word, whatever its I bit says.
  assign needs_imm_o = word_i[IMM_BIT] && !is_rsvd_s;

  assign rel_target_o = addr_i + 16'd1 + {{8{ofs_s[7]}}, ofs_s};

  // Bits [2:0] carry no meaning.
  assign unused_s = ^word_i[2:0];

endmodule

// File: rtl/decode.sv
// decode: second pipeline stage. Assembles one/two-word instructions from
// the FETCH stream, forwards ALU instructions to EXECUTE and resolves jumps
// by pulsing a new PC back to FETCH.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   fe_valid_i/fe_ready_o    : FETCH word handshake (fe_addr_i, fe_data_i)
//   fe_valid_o/fe_addr_o     : one-cycle redirect pulse with the new PC
//   ex_valid_o/ex_ready_i    : EXECUTE handshake
//   ex_addr_o .. ex_imm_o    : decoded instruction fields (held while stalled)
module decode
  import decode_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fe_valid_i,
  output logic        fe_ready_o,
  input  logic [15:0] fe_addr_i,
  input  logic [15:0] fe_data_i,
  output logic        fe_valid_o,
  output logic [15:0] fe_addr_o,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [15:0] ex_addr_o,
  output logic [3:0]  ex_op_o,
  output logic [3:0]  ex_dst_o,
  output logic [3:0]  ex_src_o,
  output logic        ex_imm_valid_o,
  output logic [15:0] ex_imm_o
);

  state_e      state_q, state_d;
  logic [15:0] exp_pc_q, exp_pc_d;
  logic [3:0]  lat_op_q, lat_dst_q, lat_src_q;
  logic [15:0] lat_addr_q;
  ex_pkt_t     ex_q, ex_d;
  logic        ex_valid_q, ex_valid_d;
  logic        fe_valid_q, fe_valid_d;
  logic [15:0] fe_addr_q, fe_addr_d;

  logic [3:0]  op_s, dst_s, src_s;
  logic        is_alu_s, is_jmp_s, needs_imm_s;
  logic [15:0] rel_target_s;

  logic        xfer_s, accept_s;
  logic        load_s, jump_s, latch_s;
  ex_pkt_t     pkt_s;
  logic [15:0] target_s;

  decode_instr u_instr (
    .word_i       (fe_data_i),
    .addr_i       (fe_addr_i),
    .op_o         (op_s),
    .dst_o        (dst_s),
    .src_o        (src_s),
    .is_alu_o     (is_alu_s),
    .is_jmp_o     (is_jmp_s),
    .needs_imm_o  (needs_imm_s),
    .rel_target_o (rel_target_s)
  );

  // No word transfers during a redirect pulse or while EXECUTE is stalled.
  assign fe_ready_o = !fe_valid_q && (!ex_valid_q || ex_ready_i);
  assign xfer_s     = fe_valid_i && fe_ready_o;
  // Words off the expected path are stale and have no effect at all.
  assign accept_s   = xfer_s && (fe_addr_i == exp_pc_q);

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_OP;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OP: begin
        if (accept_s && needs_imm_s) begin
          state_d = ST_IMM;
        end else begin
          state_d = ST_OP;
        end
      end
      ST_IMM: begin
        if (accept_s) begin
          state_d = ST_OP;
        end else begin
          state_d = ST_IMM;
        end
      end
      default: state_d = ST_OP;
    endcase
  end

  // FSM outputs: what to do with the accepted word in the current state.
  always_comb begin
    load_s   = 1'b0;
    jump_s   = 1'b0;
    latch_s  = 1'b0;
    pkt_s    = '0;
    target_s = 16'h0000;
    case (state_q)
      ST_OP: begin
        if (accept_s) begin
          if (needs_imm_s) begin
            latch_s = 1'b1;
          end else if (is_jmp_s) begin
            jump_s   = 1'b1;
            target_s = rel_target_s;
          end else if (is_alu_s) begin
            load_s         = 1'b1;
            pkt_s.addr     = fe_addr_i;
            pkt_s.op       = op_s;
            pkt_s.dst      = dst_s;
            pkt_s.src      = src_s;
            pkt_s.imm_valid = 1'b0;
            pkt_s.imm      = 16'h0000;
          end else begin
            // Reserved opcode: consumed and dropped.
            load_s = 1'b0;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      ST_IMM: begin
        if (accept_s) begin
          if (lat_op_q == OP_JMP) begin
            jump_s   = 1'b1;
            target_s = fe_data_i;
          end else begin
            load_s          = 1'b1;
            pkt_s.addr      = lat_addr_q;
            pkt_s.op        = lat_op_q;
            pkt_s.dst       = lat_dst_q;
            pkt_s.src       = lat_src_q;
            pkt_s.imm_valid = 1'b1;
            pkt_s.imm       = fe_data_i;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Next values for the expected PC and the registered outputs.
  always_comb begin
    if (jump_s) begin
      exp_pc_d = target_s;
    end else if (accept_s) begin
      exp_pc_d = exp_pc_q + 16'd1;
    end else begin
      exp_pc_d = exp_pc_q;
    end

    ex_d = ex_q;
    if (load_s) begin
      ex_d       = pkt_s;
      ex_valid_d = 1'b1;
    end else if (ex_ready_i) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end

    fe_valid_d = jump_s;
    if (jump_s) begin
      fe_addr_d = target_s;
    end else begin
      fe_addr_d = fe_addr_q;
    end
  end

  // Datapath registers: expected PC, latched opcode fields, output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exp_pc_q   <= RESET_PC;
      lat_op_q   <= 4'h0;
      lat_dst_q  <= 4'h0;
      lat_src_q  <= 4'h0;
      lat_addr_q <= 16'h0000;
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      fe_valid_q <= 1'b0;
      fe_addr_q  <= 16'h0000;
    end else begin
      exp_pc_q <= exp_pc_d;
      if (latch_s) begin
        lat_op_q   <= op_s;
        lat_dst_q  <= dst_s;
        lat_src_q  <= src_s;
        lat_addr_q <= fe_addr_i;
      end
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
      fe_valid_q <= fe_valid_d;
      fe_addr_q  <= fe_addr_d;
    end
  end

  assign fe_valid_o     = fe_valid_q;
  assign fe_addr_o      = fe_addr_q;
  assign ex_valid_o     = ex_valid_q;
  assign ex_addr_o      = ex_q.addr;
  assign ex_op_o        = ex_q.op;
  assign ex_dst_o       = ex_q.dst;
  assign ex_src_o       = ex_q.src;
  assign ex_imm_valid_o = ex_q.imm_valid;
  assign ex_imm_o       = ex_q.imm;

endmodule

// File: tb/tb_decode.sv
// tb_decode: self-checking bench for decode. A transaction-level model of the
// instruction stream predicts every EXECUTE packet and every redirect; the
// bench acts as FETCH (directed sequences, then randomized traffic).
module tb_decode;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fe_valid_i;
  logic        fe_ready_o;
  logic [15:0] fe_addr_i;
  logic [15:0] fe_data_i;
  logic        fe_valid_o;
  logic [15:0] fe_addr_o;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [15:0] ex_addr_o;
  logic [3:0]  ex_op_o;
  logic [3:0]  ex_dst_o;
  logic [3:0]  ex_src_o;
  logic        ex_imm_valid_o;
  logic [15:0] ex_imm_o;

  decode dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .fe_valid_i     (fe_valid_i),
    .fe_ready_o     (fe_ready_o),
    .fe_addr_i      (fe_addr_i),
    .fe_data_i      (fe_data_i),
    .fe_valid_o     (fe_valid_o),
    .fe_addr_o      (fe_addr_o),
    .ex_valid_o     (ex_valid_o),
    .ex_ready_i     (ex_ready_i),
    .ex_addr_o      (ex_addr_o),
    .ex_op_o        (ex_op_o),
    .ex_dst_o       (ex_dst_o),
    .ex_src_o       (ex_src_o),
    .ex_imm_valid_o (ex_imm_valid_o),
    .ex_imm_o       (ex_imm_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (instruction-stream level) -------------
  typedef struct {
    logic [15:0] addr;
    logic [3:0]  op;
    logic [3:0]  dst;
    logic [3:0]  src;
    logic        iv;
    logic [15:0] imm;
  } exp_t;

  exp_t        exq[$];
  logic [15:0] m_pc      = 16'h0000;
  bit          m_pend    = 1'b0;
  logic [15:0] m_opw     = 16'h0000;
  logic [15:0] m_opa     = 16'h0000;
  bit          m_exv     = 1'b0;
  bit          m_jmp_now = 1'b0;
  logic [15:0] m_jmp_tgt = 16'h0000;
  bit          exp_rst_next = 1'b0;
  bit          xfer_flag = 1'b0;
  bit          redir_flag = 1'b0;
  logic [15:0] redir_target = 16'h0000;

  // Check the outputs of the current cycle, then apply this cycle's inputs
  // to the model so it describes the next cycle.
  always @(negedge clk_i) begin
    bit ready_m, load, jmp;
    logic [15:0] tgt;
    exp_t e;
    int off, t;
    logic [3:0] op;

    if (exp_rst_next) begin
      check_eq("rst_ex_valid", 32'(ex_valid_o), 32'd0);
      check_eq("rst_fe_valid", 32'(fe_valid_o), 32'd0);
      check_eq("rst_fe_addr", 32'(fe_addr_o), 32'd0);
      check_eq("rst_ex_data", {ex_addr_o, ex_op_o, ex_dst_o, ex_src_o, 4'(ex_imm_valid_o)}, 32'd0);
      check_eq("rst_ex_imm", 32'(ex_imm_o), 32'd0);
      exp_rst_next = 1'b0;
    end

    check_eq("fe_valid", 32'(fe_valid_o), 32'(m_jmp_now));
    if (m_jmp_now) check_eq("fe_addr", 32'(fe_addr_o), 32'(m_jmp_tgt));
    check_eq("ex_valid", 32'(ex_valid_o), 32'(m_exv));
    if (m_exv) begin
      e = exq[0];
      check_eq("ex_addr", 32'(ex_addr_o), 32'(e.addr));
      check_eq("ex_fields", {ex_op_o, ex_dst_o, ex_src_o, 4'(ex_imm_valid_o)},
               {e.op, e.dst, e.src, 4'(e.iv)});
      check_eq("ex_imm", 32'(ex_imm_o), 32'(e.imm));
    end
    ready_m = !m_jmp_now && (!m_exv || ex_ready_i);
    check_eq("fe_ready", 32'(fe_ready_o), 32'(ready_m));

    if (rst_i) begin
      exq.delete();
      m_pc = 16'h0000; m_pend = 1'b0; m_exv = 1'b0; m_jmp_now = 1'b0;
      exp_rst_next = 1'b1; xfer_flag = 1'b0; redir_flag = 1'b0;
    end else begin
      if (m_exv && ex_ready_i) void'(exq.pop_front());
      load = 1'b0; jmp = 1'b0; tgt = 16'h0000;
      xfer_flag = fe_valid_i && ready_m;
      if (xfer_flag && fe_addr_i == m_pc) begin
        op = fe_data_i[15:12];
        if (m_pend) begin
          m_pend = 1'b0;
          if (m_opw[15:12] == 4'hF) begin
            jmp = 1'b1; tgt = fe_data_i;
          end else begin
            e.addr = m_opa; e.op = m_opw[15:12]; e.dst = m_opw[11:8];
            e.src = m_opw[7:4]; e.iv = 1'b1; e.imm = fe_data_i;
            exq.push_back(e); load = 1'b1;
          end
        end else if (op == 4'hE) begin
          // reserved: single word, dropped
        end else if (fe_data_i[3]) begin
          m_pend = 1'b1; m_opw = fe_data_i; m_opa = fe_addr_i;
        end else if (op == 4'hF) begin
          off = int'(fe_data_i[11:4]);
          if (off > 127) off = off - 256;
          t = int'(fe_addr_i) + 1 + off;
          tgt = t[15:0];
          jmp = 1'b1;
        end else begin
          e.addr = fe_addr_i; e.op = op; e.dst = fe_data_i[11:8];
          e.src = fe_data_i[7:4]; e.iv = 1'b0; e.imm = 16'h0000;
          exq.push_back(e); load = 1'b1;
        end
        m_pc = jmp ? tgt : m_pc + 16'd1;
      end
      m_exv = load ? 1'b1 : (m_exv && !ex_ready_i);
      m_jmp_now = jmp; m_jmp_tgt = tgt;
      redir_flag = jmp; redir_target = tgt;
    end
  end

  // ---------------- FETCH-side stimulus -------------------------------------
  task automatic send(input logic [15:0] a, input logic [15:0] d);
    bit done = 1'b0;
    fe_valid_i = 1'b1; fe_addr_i = a; fe_data_i = d;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (xfer_flag) begin done = 1'b1; break; end
    end
    check_eq("send_timeout", 32'(done), 32'd1);
    fe_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    fe_valid_i = 1'b0;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; fe_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  logic [15:0] mem [0:65535];

  initial begin
    logic [15:0] pc, new_pc;
    int stale;
    bit have, is_stream;

    rst_i = 1'b1; fe_valid_i = 1'b0; fe_addr_i = 16'h0000; fe_data_i = 16'h0000;
    ex_ready_i = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    repeat (2) begin @(posedge clk_i); #1; end
    rst_i = 1'b0;

    // two single-word ALU instructions back to back
    send(16'h0000, 16'h1230);
    send(16'h0001, 16'h2340);
    idle(3);

    // ALU with immediate
    do_reset();
    send(16'h0000, 16'h3418);
    send(16'h0001, 16'hBEEF);
    idle(2);

    // relative jumps, stale words, wrap at 0xFFFF, jump to own next address
    do_reset();
    send(16'h0000, 16'hF040);   // -> 0x0005
    send(16'h0001, 16'h1110);   // stale
    send(16'h0005, 16'hF0F0);   // -> 0x0015
    send(16'h0006, 16'h2220);   // stale
    send(16'h0007, 16'h3330);   // stale
    send(16'h0015, 16'h5670);   // forwarded
    send(16'h0016, 16'hFF90);   // -> 0x0010
    send(16'h0010, 16'hFFE0);   // offset -2 -> 0x000F
    send(16'h000F, 16'hFEF0);   // -> 0xFFFF
    send(16'hFFFF, 16'h1110);   // expected wraps to 0x0000
    send(16'h0000, 16'hF000);   // jump to own next address 0x0001
    send(16'h0001, 16'h2220);
    send(16'h0002, 16'hF008);   // absolute jump
    send(16'h0003, 16'h0100);
    send(16'h0100, 16'hE008);   // reserved, single word despite I
    send(16'h0101, 16'h3458);
    send(16'h0055, 16'h0000);   // stale while in ST_IMM
    send(16'h0102, 16'h4444);
    idle(3);

    // EXECUTE stall with pending output and a held FETCH word
    ex_ready_i = 1'b0;
    send(16'h0103, 16'h7650);
    fe_valid_i = 1'b1; fe_addr_i = 16'h0104; fe_data_i = 16'h8760;
    repeat (5) begin @(posedge clk_i); #1; end
    ex_ready_i = 1'b1;
    send(16'h0104, 16'h8760);
    idle(2);

    // reset while in ST_IMM
    send(16'h0105, 16'h9998);
    do_reset();
    send(16'h0000, 16'h1230);
    idle(2);

    // reset with an output pending
    ex_ready_i = 1'b0;
    send(16'h0001, 16'h2340);
    do_reset();
    ex_ready_i = 1'b1;
    send(16'h0000, 16'hA560);
    idle(2);

    // randomized traffic
    do_reset();
    pc = 16'h0000; new_pc = 16'h0000; stale = 0; have = 1'b0; is_stream = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      if (xfer_flag && have) begin
        have = 1'b0;
        if (is_stream) begin
          pc = pc + 16'd1;
          if (stale > 0) begin
            stale--;
            if (stale == 0) pc = new_pc;
          end
        end
      end
      if (redir_flag) begin
        new_pc = redir_target;
        stale = $urandom_range(0, 2);
        if (stale == 0) pc = new_pc;
      end
      if ($urandom_range(0, 499) == 0) begin
        rst_i = 1'b1; have = 1'b0; fe_valid_i = 1'b0; pc = 16'h0000; stale = 0;
      end else if (!have) begin
        if ($urandom_range(0, 9) < 2) begin
          fe_valid_i = 1'b0;
        end else begin
          have = 1'b1; fe_valid_i = 1'b1;
          if ($urandom_range(0, 9) == 0) begin
            is_stream = 1'b0;
            fe_addr_i = 16'($urandom); fe_data_i = 16'($urandom);
          end else begin
            is_stream = 1'b1;
            fe_addr_i = pc; fe_data_i = mem[pc];
          end
        end
      end
      ex_ready_i = ($urandom_range(0, 9) < 7);
    end
    rst_i = 1'b0;
    fe_valid_i = 1'b0;
    ex_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode.md
# decode

Second stage of the CPU pipeline, directly downstream of the instruction FETCH stage. Consumes the in-order stream of (address, instruction word) pairs from FETCH, assembles one- or two-word instructions, and forwards decoded ALU instructions to EXECUTE. Resolves jumps locally by sending a new PC back to FETCH and discarding stale words until the stream resumes at the target.

## Interface
- RESET_PC, 16'h0000, PC expected after reset; must match FETCH's reset address.

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- fe_valid_i  in  1  FETCH word valid
- fe_ready_o  out  1  DECODE accepts word
- fe_addr_i  in  16  address of word
- fe_data_i  in  16  instruction/immediate word
- fe_valid_o  out  1  new-PC pulse to FETCH
- fe_addr_o  out  16  new PC
- ex_valid_o  out  1  decoded instruction valid
- ex_ready_i  in  1  EXECUTE accepts
- ex_addr_o  out  16  address of opcode word
- ex_op_o  out  4  opcode
- ex_dst_o  out  4  destination register
- ex_src_o  out  4  source register
- ex_imm_valid_o  out  1  ex_imm_o replaces source register
- ex_imm_o  out  16  immediate; 0 when ex_imm_valid_o=0

## Operation
- Word format: [15:12] op, [11:8] dst, [7:4] src, [3] I (immediate follows), [2:0] ignored.
- Op 0x0-0xD: ALU; forwarded to EXECUTE. I=1: next word is the immediate.
- Op 0xE: reserved; single word regardless of I; consumed and dropped.
- Op 0xF: JMP, never forwarded. I=1: target = next word. I=0: target = opcode address + 1 + sign-extend([11:4]), modulo 2^16.
- Handshake: word transfers when fe_valid_i && fe_ready_o. fe_ready_o = !fe_valid_o && (!ex_valid_o || ex_ready_i).
- expected_pc register: transferred word with fe_addr_i != expected_pc is stale, dropped, and leaves state and expected_pc unchanged. Otherwise expected_pc increments, wrapping 0xFFFF -> 0x0000; after a JMP it is loaded with the target.
- States: ST_OP (awaiting opcode word), ST_IMM (awaiting immediate; opcode fields latched).
  - ST_OP, ALU/I=0: load output register, stay.
  - ST_OP, ALU/I=1 or JMP/I=1: latch fields, go to ST_IMM.
  - ST_OP, JMP/I=0: issue jump, stay.
  - ST_IMM, valid word: complete ALU (load output with ex_imm_o = word) or JMP (target = word); go to ST_OP.
- Jump issue: fe_valid_o=1 with fe_addr_o=target for exactly one cycle.
- ex_* outputs are held stable while ex_valid_o && !ex_ready_i; ex_valid_o drops after acceptance unless a new instruction is loaded in the same cycle.
- Reset values: state ST_OP, expected_pc=RESET_PC, ex_valid_o=0, fe_valid_o=0, fe_addr_o=0, all ex_* data outputs 0.

## Timing
- Final word accepted in cycle N -> ex_valid_o (or fe_valid_o) high in cycle N+1. All outputs registered except fe_ready_o.
- Throughput one instruction per cycle when ex_ready_i held high; ex_ready_i and a new word in the same cycle both transfer.
- fe_ready_o is low during the fe_valid_o cycle, so no word transfers while FETCH is redirected.
- JMP to its own expected next address: jump still issued; following words with matching addresses are accepted normally.
- rst_i mid-instruction (ST_IMM or ex_valid_o pending): everything returns to reset values the next cycle; the partial instruction is lost.
- Stale word arriving in ST_IMM: dropped, remain in ST_IMM.

## Structure
- Package decode_pkg: opcode constants (OP_RSVD=4'hE, OP_JMP=4'hF), field bit positions, state enum (ST_OP, ST_IMM).
- One sub-module decode_instr: combinational field extraction, classification (alu/jmp/rsvd, needs_imm) and relative-target adder.

## Test plan
- Reset, then words 0x0000:0x1230, 0x0001:0x2340 with ex_ready_i=1 -> two cycles of ex_valid_o, ex_addr_o 0x0000 then 0x0001, ex_op_o 1 then 2, ex_imm_valid_o=0.
- 0x0000:0x3418 then 0x0001:0xBEEF -> single output: op 3, dst 4, src 1, ex_imm_o 0xBEEF, ex_addr_o 0x0000.
- 0x0005:0xF0F0 (JMP rel, offset 0x0F) -> fe_valid_o one cycle with fe_addr_o 0x0015; later words at 0x0006, 0x0007 dropped; word at 0x0015 forwarded.
- 0x0010:0xFFE0 (offset -2) -> fe_addr_o 0x000F. Word at 0xFFFF with I=0 -> next expected 0x0000.
- ex_ready_i=0 for 5 cycles with pending output -> ex_* stable, fe_ready_o=0, FETCH word held.
- rst_i asserted while in ST_IMM with ex_valid_o=1 -> next cycle ex_valid_o=0, ST_OP, expected_pc=RESET_PC.
